// File: rtl/axi4_b_err_inject.sv
// Merges downstream B responses with locally injected SLVERR
// responses for writes the RAB dropped; feeds the B buffer.
//
// Ports:
//   axi4_aclk, axi4_arstn       clock, async active-low reset
//   drop_i/drop_id_i/drop_user_i/drop_ready_o
//                               record one dropped write
//   done_i                      W burst of oldest undone drop sunk
//   m_axi4_b*                   downstream B channel (input side)
//   s_axi4_b*                   merged B channel (to B buffer)
//   err_cnt_o                   injected-error count
// Optional: define AXI4_B_ERR_CNT_EN to build the error counter.
module axi4_b_err_inject #(
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_USER_WIDTH = 4,
  parameter int DROP_DEPTH     = 4
) (
  input  logic                      axi4_aclk,
  input  logic                      axi4_arstn,
  input  logic                      drop_i,
  input  logic [AXI_ID_WIDTH-1:0]   drop_id_i,
  input  logic [AXI_USER_WIDTH-1:0] drop_user_i,
  output logic                      drop_ready_o,
  input  logic                      done_i,
  input  logic [AXI_ID_WIDTH-1:0]   m_axi4_bid,
  input  logic [1:0]                m_axi4_bresp,
  input  logic                      m_axi4_bvalid,
  input  logic [AXI_USER_WIDTH-1:0] m_axi4_buser,
  output logic                      m_axi4_bready,
  output logic [AXI_ID_WIDTH-1:0]   s_axi4_bid,
  output logic [1:0]                s_axi4_bresp,
  output logic                      s_axi4_bvalid,
  output logic [AXI_USER_WIDTH-1:0] s_axi4_buser,
  input  logic                      s_axi4_bready,
  output logic [31:0]               err_cnt_o
);

  localparam int PW = $clog2(DROP_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    ERR  = 2'd2
  } sel_t;

  logic [AXI_ID_WIDTH-1:0]   id_q   [DROP_DEPTH];
  logic [AXI_USER_WIDTH-1:0] user_q [DROP_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, done_cnt;
  sel_t          lock, sel;
  logic          last_err;

  logic full, push, pop, hs;
  logic err_ok, done_inc;

  assign full         = (count == CW'(DROP_DEPTH));
  assign drop_ready_o = !full;
  assign push         = drop_i && !full;
  assign err_ok       = (done_cnt != '0);
  assign done_inc     = done_i && (done_cnt < count);

  // A locked source keeps the channel until its beat is taken.
  // Gated by reset so nothing is offered while in reset.
  always_comb begin
    sel = IDLE;
    if (!axi4_arstn)
      sel = IDLE;
    else if (lock != IDLE)
      sel = lock;
    else if (err_ok && m_axi4_bvalid)
      sel = last_err ? FWD : ERR;
    else if (err_ok)
      sel = ERR;
    else if (m_axi4_bvalid)
      sel = FWD;
  end

  always_comb begin
    s_axi4_bid    = '0;
    s_axi4_bresp  = 2'b00;
    s_axi4_bvalid = 1'b0;
    s_axi4_buser  = '0;
    m_axi4_bready = 1'b0;
    unique case (1'b1)
      (sel == FWD): begin
        s_axi4_bid    = m_axi4_bid;
        s_axi4_bresp  = m_axi4_bresp;
        s_axi4_bvalid = m_axi4_bvalid;
        s_axi4_buser  = m_axi4_buser;
        m_axi4_bready = s_axi4_bready;
      end
      (sel == ERR): begin
        s_axi4_bid    = id_q[rd_ptr];
        s_axi4_bresp  = 2'b10;
        s_axi4_bvalid = 1'b1;
        s_axi4_buser  = user_q[rd_ptr];
      end
      default: ;
    endcase
  end

  assign hs  = s_axi4_bvalid && s_axi4_bready;
  assign pop = hs && (sel == ERR);

  always_ff @(posedge axi4_aclk) begin
    if (push) begin
      id_q[wr_ptr]   <= drop_id_i;
      user_q[wr_ptr] <= drop_user_i;
    end
  end

  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      done_cnt <= '0;
      lock     <= IDLE;
      last_err <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      unique case ({done_inc, pop})
        2'b10:   done_cnt <= done_cnt + 1'b1;
        2'b01:   done_cnt <= done_cnt - 1'b1;
        default: ;
      endcase
      lock <= (s_axi4_bvalid && !s_axi4_bready) ? sel : IDLE;
      if (hs) last_err <= (sel == ERR);
    end
  end

`ifdef AXI4_B_ERR_CNT_EN
  logic [31:0] err_cnt;
  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn)
      err_cnt <= '0;
    else if (pop)
      err_cnt <= err_cnt + 32'd1;
  end
  assign err_cnt_o = err_cnt;
`else
  assign err_cnt_o = 32'd0;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge axi4_aclk) begin
    if (axi4_arstn && done_i)
      assert (done_cnt < count)
        else $warning("done_i with no undone drop, ignored");
  end
`endif

endmodule

// File: tb/tb_axi4_b_err_inject.sv
// Directed bench for axi4_b_err_inject: pass-through, injection,
// arbitration, backpressure lock, full FIFO and mid-run reset.
module tb_axi4_b_err_inject;

`ifdef AXI4_B_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        drop_i;
  logic [3:0]  drop_id_i, drop_user_i;
  logic        drop_ready_o;
  logic        done_i;
  logic [3:0]  m_bid, m_buser;
  logic [1:0]  m_bresp;
  logic        m_bvalid, m_bready;
  logic [3:0]  s_bid, s_buser;
  logic [1:0]  s_bresp;
  logic        s_bvalid, s_bready;
  logic [31:0] err_cnt_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axi4_b_err_inject dut (
    .axi4_aclk     (clk),
    .axi4_arstn    (rst_n),
    .drop_i        (drop_i),
    .drop_id_i     (drop_id_i),
    .drop_user_i   (drop_user_i),
    .drop_ready_o  (drop_ready_o),
    .done_i        (done_i),
    .m_axi4_bid    (m_bid),
    .m_axi4_bresp  (m_bresp),
    .m_axi4_bvalid (m_bvalid),
    .m_axi4_buser  (m_buser),
    .m_axi4_bready (m_bready),
    .s_axi4_bid    (s_bid),
    .s_axi4_bresp  (s_bresp),
    .s_axi4_bvalid (s_bvalid),
    .s_axi4_buser  (s_buser),
    .s_axi4_bready (s_bready),
    .err_cnt_o     (err_cnt_o)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    drop_i = 0; drop_id_i = 0; drop_user_i = 0;
    done_i = 0;
    m_bid = 0; m_bresp = 0; m_bvalid = 0; m_buser = 0;
    s_bready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    m_bvalid = 1;
    s_bready = 1;
    @(posedge clk);
    #2;
    checks++;
    if (s_bvalid !== 1'b0) begin
      failures++;
      $display("FAIL rst_svalid got=%0b exp=0", s_bvalid);
    end
    checks++;
    if (m_bready !== 1'b0) begin
      failures++;
      $display("FAIL rst_mready got=%0b exp=0", m_bready);
    end
    checks++;
    if (drop_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL rst_dready got=%0b exp=1", drop_ready_o);
    end
    checks++;
    if (err_cnt_o !== 32'd0) begin
      failures++;
      $display("FAIL rst_errcnt got=%0d exp=0", err_cnt_o);
    end
    do_reset();
  endtask

  task automatic test_passthrough();
    m_bvalid = 1; m_bid = 3; m_bresp = 0; m_buser = 7;
    s_bready = 1;
    #1;
    checks++;
    if ({s_bvalid, s_bid, s_bresp, s_buser, m_bready}
        !== {1'b1, 4'd3, 2'b00, 4'd7, 1'b1}) begin
      failures++;
      $display("FAIL pt got=%b/%0h/%b/%0h/%b exp=1/3/00/7/1",
               s_bvalid, s_bid, s_bresp, s_buser, m_bready);
    end
    m_bresp = 2'b01; m_bid = 4'hc;
    #1;
    checks++;
    if ({s_bid, s_bresp} !== {4'hc, 2'b01}) begin
      failures++;
      $display("FAIL pt_exok got=%0h/%b exp=c/01", s_bid, s_bresp);
    end
    cyc();
    m_bvalid = 0;
    #1;
  endtask

  task automatic test_single_drop();
    s_bready = 0;
    drop_i = 1; drop_id_i = 5; drop_user_i = 2;
    cyc();
    drop_i = 0;
    #1;
    checks++;
    if (s_bvalid !== 1'b0) begin
      failures++;
      $display("FAIL sd_notdone got=%0b exp=0", s_bvalid);
    end
    cyc();
    cyc();
    done_i = 1;
    #1;
    checks++;
    if (s_bvalid !== 1'b0) begin
      failures++;
      $display("FAIL sd_donecyc got=%0b exp=0", s_bvalid);
    end
    cyc();
    done_i = 0;
    #1;
    checks++;
    if ({s_bvalid, s_bid, s_buser, s_bresp, m_bready}
        !== {1'b1, 4'd5, 4'd2, 2'b10, 1'b0}) begin
      failures++;
      $display("FAIL sd_err got=%b/%0h/%0h/%b/%b exp=1/5/2/10/0",
               s_bvalid, s_bid, s_buser, s_bresp, m_bready);
    end
    s_bready = 1;
    cyc();
    checks++;
    if ({s_bvalid, drop_ready_o} !== 2'b01) begin
      failures++;
      $display("FAIL sd_popped got=%b exp=01", {s_bvalid, drop_ready_o});
    end
    checks++;
    if (err_cnt_o !== (CNT_EN ? 32'd1 : 32'd0)) begin
      failures++;
      $display("FAIL sd_errcnt got=%0d exp=%0d", err_cnt_o, CNT_EN ? 1 : 0);
    end
  endtask

  task automatic test_contention();
    logic [3:0] exp_id [5];
    logic       exp_err [5];
    exp_id[0] = 4'h9; exp_err[0] = 0;
    exp_id[1] = 4'h1; exp_err[1] = 1;
    exp_id[2] = 4'h9; exp_err[2] = 0;
    exp_id[3] = 4'h2; exp_err[3] = 1;
    exp_id[4] = 4'h9; exp_err[4] = 0;
    do_reset();
    drop_i = 1; drop_id_i = 1; drop_user_i = 0;
    cyc();
    drop_id_i = 2;
    cyc();
    drop_i = 0;
    done_i = 1;
    cyc();
    m_bvalid = 1; m_bid = 9; m_bresp = 0; m_buser = 0;
    s_bready = 1;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if ({s_bvalid, s_bid, s_bresp, m_bready}
          !== {1'b1, exp_id[k], exp_err[k] ? 2'b10 : 2'b00,
               !exp_err[k]}) begin
        failures++;
        $display("FAIL cont_%0d got=%b/%0h/%b/%b exp_id=%0h err=%0b",
                 k, s_bvalid, s_bid, s_bresp, m_bready,
                 exp_id[k], exp_err[k]);
      end
      cyc();
      done_i = 0;
    end
    m_bvalid = 0;
    #1;
    checks++;
    if (err_cnt_o !== (CNT_EN ? 32'd2 : 32'd0)) begin
      failures++;
      $display("FAIL cont_errcnt got=%0d exp=%0d", err_cnt_o, CNT_EN ? 2 : 0);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    drop_i = 1; drop_id_i = 6; drop_user_i = 4;
    cyc();
    drop_i = 0;
    done_i = 1;
    cyc();
    done_i = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        m_bvalid = 1; m_bid = 4'ha; m_bresp = 0;
      end
      #1;
      checks++;
      if ({s_bvalid, s_bid, s_bresp, m_bready}
          !== {1'b1, 4'd6, 2'b10, 1'b0}) begin
        failures++;
        $display("FAIL bp_hold_%0d got=%b/%0h/%b/%b exp=1/6/10/0",
                 i, s_bvalid, s_bid, s_bresp, m_bready);
      end
      cyc();
    end
    s_bready = 1;
    #1;
    checks++;
    if ({s_bvalid, s_bid, s_bresp, m_bready}
        !== {1'b1, 4'd6, 2'b10, 1'b0}) begin
      failures++;
      $display("FAIL bp_accept got=%b/%0h/%b/%b exp=1/6/10/0",
               s_bvalid, s_bid, s_bresp, m_bready);
    end
    cyc();
    checks++;
    if ({s_bvalid, s_bid, s_bresp, m_bready}
        !== {1'b1, 4'ha, 2'b00, 1'b1}) begin
      failures++;
      $display("FAIL bp_fwd got=%b/%0h/%b/%b exp=1/a/00/1",
               s_bvalid, s_bid, s_bresp, m_bready);
    end
    cyc();
    m_bvalid = 0;
    s_bready = 0;
    #1;
  endtask

  task automatic test_full_fifo();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drop_i = 1;
      drop_id_i = 4'(k + 1);
      drop_user_i = 4'(k + 8);
      cyc();
    end
    drop_i = 0;
    #1;
    checks++;
    if (drop_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL ff_full got=%0b exp=0", drop_ready_o);
    end
    drop_i = 1; drop_id_i = 4'hf; drop_user_i = 4'hf;
    cyc();
    drop_i = 0;
    done_i = 1;
    repeat (5) cyc();
    done_i = 0;
    s_bready = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if ({s_bvalid, s_bid, s_buser, s_bresp}
          !== {1'b1, 4'(k + 1), 4'(k + 8), 2'b10}) begin
        failures++;
        $display("FAIL ff_pop_%0d got=%b/%0h/%0h/%b exp=1/%0h/%0h/10",
                 k, s_bvalid, s_bid, s_buser, s_bresp, k + 1, k + 8);
      end
      cyc();
      if (k == 0) begin
        checks++;
        if (drop_ready_o !== 1'b1) begin
          failures++;
          $display("FAIL ff_ready got=%0b exp=1", drop_ready_o);
        end
      end
    end
    checks++;
    if (s_bvalid !== 1'b0) begin
      failures++;
      $display("FAIL ff_empty got=%0b exp=0", s_bvalid);
    end
    drop_i = 1; drop_id_i = 7; drop_user_i = 1;
    cyc();
    drop_i = 0;
    #1;
    checks++;
    if (s_bvalid !== 1'b0) begin
      failures++;
      $display("FAIL ff_5th_done got=%0b exp=0", s_bvalid);
    end
    s_bready = 0;
  endtask

  task automatic test_reset_mid_err();
    do_reset();
    drop_i = 1; drop_id_i = 1; drop_user_i = 3;
    cyc();
    drop_id_i = 2;
    cyc();
    drop_i = 0;
    done_i = 1;
    cyc();
    cyc();
    done_i = 0;
    #1;
    checks++;
    if ({s_bvalid, s_bid} !== {1'b1, 4'd1}) begin
      failures++;
      $display("FAIL rm_pre got=%b/%0h exp=1/1", s_bvalid, s_bid);
    end
    rst_n = 0;
    #1;
    checks++;
    if ({s_bvalid, m_bready} !== 2'b00) begin
      failures++;
      $display("FAIL rm_inrst got=%b exp=00", {s_bvalid, m_bready});
    end
    @(posedge clk);
    #1 rst_n = 1;
    #1;
    checks++;
    if ({s_bvalid, drop_ready_o} !== 2'b01) begin
      failures++;
      $display("FAIL rm_post got=%b exp=01", {s_bvalid, drop_ready_o});
    end
    checks++;
    if (err_cnt_o !== 32'd0) begin
      failures++;
      $display("FAIL rm_errcnt got=%0d exp=0", err_cnt_o);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_passthrough();
    test_single_drop();
    test_contention();
    test_backpressure();
    test_full_fifo();
    test_reset_mid_err();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
